motoro3_step_sequencer: RTL and testbench

MOTORO3_STEP_SEQUENCER -- requirements
Module: motoro3_step_sequencer

---
 rtl/motoro3_pkg.sv | 35 +++
 rtl/motoro3_step_timer.sv | 34 +++
 rtl/motoro3_step_sequencer.sv | 150 +++++++++++++++
 tb/tb_motoro3_step_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 step sequencer: FSM encoding,
// shadow-config layout with its reset defaults, and the sub-step terminal rule.
package motoro3_pkg;

  localparam int STEP_NUM_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  typedef struct packed {
    logic [24:0] speed;
    logic [1:0]  split_max;
    logic [7:0]  power;
    logic [11:0] pwm_len;
    logic [11:0] pwm_mask;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    speed:     25'd1000,
    split_max: 2'd0,
    power:     8'd1,
    pwm_len:   12'd0,
    pwm_mask:  12'd0
  };

  // A zero speed setting would give a one-clock sub-step; clamp it to two clocks.
  function automatic logic [24:0] term_of(input logic [24:0] speed);
    return (speed == 25'd0) ? 25'd1 : speed;
  endfunction

endpackage

// File: rtl/motoro3_step_timer.sv
// Sub-step counter: free-runs while enabled and wraps to 0 after reaching term_val.
module motoro3_step_timer
  import motoro3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [24:0] term_val,
  output logic        term
);

  logic [24:0] cnt_q, cnt_d;

  assign term = en && (cnt_q == term_val);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 25'd0;
    end else if (en) begin
      cnt_d = term ? 25'd0 : cnt_q + 25'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 25'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer: walks lcStep/split through sub-steps timed by the
// step timer, with shadowed configuration that only reloads on step boundaries.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int STEP_NUM = STEP_NUM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m3r_start,
  input  logic        m3r_cfgUpdate,
  input  logic [24:0] m3r_stepCNT_speedSET,
  input  logic [1:0]  m3r_stepSplitMax,
  input  logic [7:0]  m3r_power_percent,
  input  logic [11:0] m3r_pwmLenWant,
  input  logic [11:0] m3r_pwmMinMask,
  output logic [3:0]  lcStep,
  output logic [1:0]  m3LpwmSplitStep,
  output logic [24:0] sh_stepCNT_speedSET,
  output logic [1:0]  sh_stepSplitMax,
  output logic [7:0]  sh_power_percent,
  output logic [11:0] sh_pwmLenWant,
  output logic [11:0] sh_pwmMinMask,
  output logic        subStepStart,
  output logic        cycleDone,
  output logic        busy
);

  localparam logic [3:0] STEP_LAST = 4'(STEP_NUM - 1);

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [1:0] split_q, split_d;
  logic       pending_q, pending_d;
  cfg_t       sh_q, sh_d;
  logic       sss_q, sss_d;
  logic       cd_q, cd_d;
  logic       busy_q, busy_d;

  cfg_t cfg_in;
  logic tmr_clr, tmr_en, term, boundary, upd;

  assign cfg_in = '{
    speed:     m3r_stepCNT_speedSET,
    split_max: m3r_stepSplitMax,
    power:     m3r_power_percent,
    pwm_len:   m3r_pwmLenWant,
    pwm_mask:  m3r_pwmMinMask
  };

  assign tmr_clr  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign tmr_en   = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign boundary = term && (split_q == sh_q.split_max);
  assign upd      = pending_q || m3r_cfgUpdate;

  motoro3_step_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .term_val (term_of(sh_q.speed)),
    .term     (term)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    split_d   = split_q;
    pending_d = upd;
    sh_d      = sh_q;
    sss_d     = 1'b0;
    cd_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        step_d  = 4'd0;
        split_d = 2'd0;
        if (m3r_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sh_d      = cfg_in;
        pending_d = 1'b0;
        step_d    = 4'd0;
        split_d   = 2'd0;
        sss_d     = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        if ((state_q == ST_RUN) && !m3r_start) state_d = ST_STOP;
        if (term) begin
          sss_d = 1'b1;
          if (!boundary) begin
            split_d = split_q + 2'd1;
          end else begin
            split_d = 2'd0;
            if (upd) begin
              sh_d      = cfg_in;
              pending_d = 1'b0;
            end
            // A stop request finishes here: park at step 0 without a new sub-step.
            if (state_q == ST_STOP) begin
              state_d = ST_IDLE;
              step_d  = 4'd0;
              sss_d   = 1'b0;
            end else if (step_q == STEP_LAST) begin
              step_d = 4'd0;
              cd_d   = 1'b1;
            end else begin
              step_d = step_q + 4'd1;
            end
          end
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= 4'd0;
      split_q   <= 2'd0;
      pending_q <= 1'b0;
      sh_q      <= CFG_RST;
      sss_q     <= 1'b0;
      cd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      split_q   <= split_d;
      pending_q <= pending_d;
      sh_q      <= sh_d;
      sss_q     <= sss_d;
      cd_q      <= cd_d;
      busy_q    <= busy_d;
    end
  end

  assign lcStep              = step_q;
  assign m3LpwmSplitStep     = split_q;
  assign sh_stepCNT_speedSET = sh_q.speed;
  assign sh_stepSplitMax     = sh_q.split_max;
  assign sh_power_percent    = sh_q.power;
  assign sh_pwmLenWant       = sh_q.pwm_len;
  assign sh_pwmMinMask       = sh_q.pwm_mask;
  assign subStepStart        = sss_q;
  assign cycleDone           = cd_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed bench for motoro3_step_sequencer; inputs change and outputs are
// sampled on the falling clock edge. Cycle index e counts rising edges after start.
module tb_motoro3_step_sequencer;

  logic        clk;
  logic        rst;
  logic        m3r_start;
  logic        m3r_cfgUpdate;
  logic [24:0] m3r_stepCNT_speedSET;
  logic [1:0]  m3r_stepSplitMax;
  logic [7:0]  m3r_power_percent;
  logic [11:0] m3r_pwmLenWant;
  logic [11:0] m3r_pwmMinMask;
  logic [3:0]  lcStep;
  logic [1:0]  m3LpwmSplitStep;
  logic [24:0] sh_stepCNT_speedSET;
  logic [1:0]  sh_stepSplitMax;
  logic [7:0]  sh_power_percent;
  logic [11:0] sh_pwmLenWant;
  logic [11:0] sh_pwmMinMask;
  logic        subStepStart;
  logic        cycleDone;
  logic        busy;

  int errors = 0;
  int checks = 0;

  motoro3_step_sequencer #(.STEP_NUM(12)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .m3r_start            (m3r_start),
    .m3r_cfgUpdate        (m3r_cfgUpdate),
    .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
    .m3r_stepSplitMax     (m3r_stepSplitMax),
    .m3r_power_percent    (m3r_power_percent),
    .m3r_pwmLenWant       (m3r_pwmLenWant),
    .m3r_pwmMinMask       (m3r_pwmMinMask),
    .lcStep               (lcStep),
    .m3LpwmSplitStep      (m3LpwmSplitStep),
    .sh_stepCNT_speedSET  (sh_stepCNT_speedSET),
    .sh_stepSplitMax      (sh_stepSplitMax),
    .sh_power_percent     (sh_power_percent),
    .sh_pwmLenWant        (sh_pwmLenWant),
    .sh_pwmMinMask        (sh_pwmMinMask),
    .subStepStart         (subStepStart),
    .cycleDone            (cycleDone),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_rst();
    m3r_start     = 1'b0;
    m3r_cfgUpdate = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [24:0] spd, input logic [1:0] smax, input logic [7:0] pwr,
                         input logic [11:0] len, input logic [11:0] mask);
    m3r_stepCNT_speedSET = spd;
    m3r_stepSplitMax     = smax;
    m3r_power_percent    = pwr;
    m3r_pwmLenWant       = len;
    m3r_pwmMinMask       = mask;
  endtask

  task automatic test_reset();
    set_cfg(25'd77, 2'd2, 8'd99, 12'hFFF, 12'hFFF);
    m3r_start = 1'b1;
    m3r_cfgUpdate = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (lcStep !== 4'd0) begin errors++; $display("FAIL rst_lcStep got=%0d exp=0", lcStep); end
    checks++; if (m3LpwmSplitStep !== 2'd0) begin errors++; $display("FAIL rst_split got=%0d exp=0", m3LpwmSplitStep); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (subStepStart !== 1'b0 || cycleDone !== 1'b0) begin errors++; $display("FAIL rst_pulses got=%b%b exp=00", subStepStart, cycleDone); end
    checks++; if (sh_stepCNT_speedSET !== 25'd1000) begin errors++; $display("FAIL rst_sh_speed got=%0d exp=1000", sh_stepCNT_speedSET); end
    checks++; if (sh_stepSplitMax !== 2'd0) begin errors++; $display("FAIL rst_sh_split got=%0d exp=0", sh_stepSplitMax); end
    checks++; if (sh_power_percent !== 8'd1) begin errors++; $display("FAIL rst_sh_power got=%0d exp=1", sh_power_percent); end
    checks++; if (sh_pwmLenWant !== 12'd0 || sh_pwmMinMask !== 12'd0) begin errors++; $display("FAIL rst_sh_pwm got=%0h/%0h exp=0/0", sh_pwmLenWant, sh_pwmMinMask); end
    rst = 1'b0;
    m3r_start = 1'b0;
    m3r_cfgUpdate = 1'b0;
  endtask

  // speed=3, splitMax=0: lcStep advances every 4 clocks, one cycleDone per 48.
  task automatic test_basic_run();
    int cd_cnt;
    int exp_step;
    logic exp_ss;
    cd_cnt = 0;
    apply_rst();
    set_cfg(25'd3, 2'd0, 8'd40, 12'h200, 12'h010);
    m3r_start = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clk);
      exp_step = (e >= 2) ? ((e - 2) / 4) % 12 : 0;
      exp_ss   = (e >= 2) && ((e - 2) % 4 == 0);
      if (cycleDone === 1'b1) cd_cnt++;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy e=%0d got=%b exp=1", e, busy); end
      checks++; if (lcStep !== 4'(exp_step)) begin errors++; $display("FAIL run_step e=%0d got=%0d exp=%0d", e, lcStep, exp_step); end
      checks++; if (subStepStart !== exp_ss) begin errors++; $display("FAIL run_sss e=%0d got=%b exp=%b", e, subStepStart, exp_ss); end
      checks++; if (cycleDone !== (e == 50)) begin errors++; $display("FAIL run_cd e=%0d got=%b exp=%b", e, cycleDone, (e == 50)); end
      if (e == 2) begin
        checks++; if (sh_stepCNT_speedSET !== 25'd3 || sh_power_percent !== 8'd40) begin errors++; $display("FAIL run_load got=%0d/%0d exp=3/40", sh_stepCNT_speedSET, sh_power_percent); end
      end
    end
    checks++; if (cd_cnt != 1) begin errors++; $display("FAIL run_cd_count got=%0d exp=1", cd_cnt); end
  endtask

  // speed=0 behaves as 1: two-clock sub-steps, split 0..3, lcStep every 8 clocks.
  task automatic test_split_zero_speed();
    int exp_split;
    int exp_step;
    logic exp_ss;
    apply_rst();
    set_cfg(25'd0, 2'd3, 8'd60, 12'h100, 12'h001);
    m3r_start = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      @(negedge clk);
      exp_split = (e >= 2) ? ((e - 2) / 2) % 4 : 0;
      exp_step  = (e >= 2) ? ((e - 2) / 8) % 12 : 0;
      exp_ss    = (e >= 2) && ((e - 2) % 2 == 0);
      checks++; if (m3LpwmSplitStep !== 2'(exp_split)) begin errors++; $display("FAIL split_split e=%0d got=%0d exp=%0d", e, m3LpwmSplitStep, exp_split); end
      checks++; if (lcStep !== 4'(exp_step)) begin errors++; $display("FAIL split_step e=%0d got=%0d exp=%0d", e, lcStep, exp_step); end
      checks++; if (subStepStart !== exp_ss) begin errors++; $display("FAIL split_sss e=%0d got=%b exp=%b", e, subStepStart, exp_ss); end
    end
  endtask

  // Shadow reload only at step boundaries (edges 10, 18, 26 with 8-clock steps).
  task automatic test_cfg_update();
    int exp_pwr;
    apply_rst();
    set_cfg(25'd3, 2'd1, 8'd10, 12'h050, 12'h005);
    m3r_start = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      if (e == 4) begin m3r_cfgUpdate = 1'b1; m3r_power_percent = 8'd50; end
      if (e == 5) m3r_cfgUpdate = 1'b0;
      if (e == 11) m3r_power_percent = 8'd77;
      if (e == 26) begin m3r_cfgUpdate = 1'b1; m3r_power_percent = 8'd88; end
      @(negedge clk);
      exp_pwr = (e < 2) ? 1 : (e < 10) ? 10 : (e < 26) ? 50 : 88;
      checks++; if (sh_power_percent !== 8'(exp_pwr)) begin errors++; $display("FAIL upd_power e=%0d got=%0d exp=%0d", e, sh_power_percent, exp_pwr); end
      if (e >= 2) begin
        checks++; if (lcStep !== 4'((e - 2) / 8)) begin errors++; $display("FAIL upd_step e=%0d got=%0d exp=%0d", e, lcStep, (e - 2) / 8); end
        checks++; if (m3LpwmSplitStep !== 2'(((e - 2) / 4) % 2)) begin errors++; $display("FAIL upd_split e=%0d got=%0d exp=%0d", e, m3LpwmSplitStep, ((e - 2) / 4) % 2); end
      end
    end
    m3r_cfgUpdate = 1'b0;
  endtask

  // Stop requested at split 1: finish splits 2,3, park in IDLE; start during STOP is ignored.
  task automatic test_stop();
    logic [1:0] exp_split [11] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    logic       exp_busy  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_rst();
    set_cfg(25'd0, 2'd3, 8'd30, 12'h0AA, 12'h00F);
    m3r_start = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      if (e == 5) m3r_start = 1'b0;
      if (e == 8) m3r_start = 1'b1;
      @(negedge clk);
      checks++; if (m3LpwmSplitStep !== exp_split[e-1]) begin errors++; $display("FAIL stop_split e=%0d got=%0d exp=%0d", e, m3LpwmSplitStep, exp_split[e-1]); end
      checks++; if (busy !== exp_busy[e-1]) begin errors++; $display("FAIL stop_busy e=%0d got=%b exp=%b", e, busy, exp_busy[e-1]); end
      checks++; if (lcStep !== 4'd0) begin errors++; $display("FAIL stop_step e=%0d got=%0d exp=0", e, lcStep); end
      if (e == 10) begin
        checks++; if (subStepStart !== 1'b0) begin errors++; $display("FAIL stop_sss got=%b exp=0", subStepStart); end
      end
    end
    m3r_start = 1'b0;
  endtask

  // Reset at lcStep=7 overrides a concurrent cfgUpdate and the running sequence.
  task automatic test_reset_mid_run();
    apply_rst();
    set_cfg(25'd3, 2'd0, 8'd200, 12'hABC, 12'h123);
    m3r_start = 1'b1;
    for (int e = 1; e <= 31; e++) @(negedge clk);
    checks++; if (lcStep !== 4'd7 || sh_power_percent !== 8'd200) begin errors++; $display("FAIL midrst_pre got=%0d/%0d exp=7/200", lcStep, sh_power_percent); end
    rst = 1'b1;
    m3r_cfgUpdate = 1'b1;
    @(negedge clk);
    checks++; if (lcStep !== 4'd0 || m3LpwmSplitStep !== 2'd0) begin errors++; $display("FAIL midrst_step got=%0d/%0d exp=0/0", lcStep, m3LpwmSplitStep); end
    checks++; if (busy !== 1'b0 || subStepStart !== 1'b0 || cycleDone !== 1'b0) begin errors++; $display("FAIL midrst_ctl got=%b%b%b exp=000", busy, subStepStart, cycleDone); end
    checks++; if (sh_stepCNT_speedSET !== 25'd1000 || sh_stepSplitMax !== 2'd0) begin errors++; $display("FAIL midrst_sh_speed got=%0d/%0d exp=1000/0", sh_stepCNT_speedSET, sh_stepSplitMax); end
    checks++; if (sh_power_percent !== 8'd1 || sh_pwmLenWant !== 12'd0 || sh_pwmMinMask !== 12'd0) begin errors++; $display("FAIL midrst_sh_pwm got=%0d/%0h/%0h exp=1/0/0", sh_power_percent, sh_pwmLenWant, sh_pwmMinMask); end
    rst = 1'b0;
    m3r_cfgUpdate = 1'b0;
    m3r_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m3r_start = 1'b0;
    m3r_cfgUpdate = 1'b0;
    set_cfg(25'd0, 2'd0, 8'd0, 12'd0, 12'd0);
    test_reset();
    test_basic_run();
    test_split_zero_speed();
    test_cfg_update();
    test_stop();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
